div_seq: RTL

- Iterative radix-2 restoring divide sequencer for the multicycle ARM core.
- Launched by the main control FSM when it decodes a divide and asserts div_op in the execute state.
- Holds the core in a stall via busy, then returns quotient and remainder for the ALU write-back path.
- Handles signed/unsigned operands, divide-by-zero and flush.

---
 rtl/div_seq_pkg.sv | 17 +
 rtl/div_seq_step.sv | 22 ++
 rtl/div_seq.sv | 118 +++++++++++
 3 files changed

// File: rtl/div_seq_pkg.sv
// Shared definitions for the iterative restoring divider: state encoding,
// default operand width and the divide-by-zero quotient pattern.
package div_seq_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Wide enough for any supported WIDTH; the top slices off what it needs.
    localparam logic [63:0] DBZ_QUOT = '1;

endpackage

// File: rtl/div_seq_step.sv
// One radix-2 restoring iteration: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference only when it does not go negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             quot_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem < divisor on entry, so shifted < 2*divisor and bit WIDTH of diff is a clean sign.
    assign shifted  = {rem, dividend_bit};
    assign diff     = shifted - {1'b0, divisor};
    assign quot_bit = ~diff[WIDTH];
    assign rem_next = quot_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_seq.sv
// Multicycle signed/unsigned divide sequencer: stalls the core via busy for
// WIDTH restoring steps plus a sign-fix cycle, then pulses done with results.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;       // dividend magnitude, becomes quotient as bits shift in
    logic [WIDTH-1:0] b_reg;       // divisor magnitude
    logic [WIDTH-1:0] p_reg;       // partial remainder
    logic             sign_a_reg;
    logic             sign_b_reg;
    logic [CNT_W-1:0] count_reg;

    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;

    assign dividend_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign divisor_mag  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

    assign busy = (state_reg != IDLE);

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem         (p_reg),
        .dividend_bit(a_reg[WIDTH-1]),
        .divisor     (b_reg),
        .rem_next    (step_rem),
        .quot_bit    (step_qbit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            p_reg       <= '0;
            sign_a_reg  <= 1'b0;
            sign_b_reg  <= 1'b0;
            count_reg   <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state_reg <= IDLE;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            if (divisor == '0) begin
                                quotient    <= DBZ_QUOT[WIDTH-1:0];
                                remainder   <= dividend;
                                div_by_zero <= 1'b1;
                                done        <= 1'b1;
                                state_reg   <= DONE;
                            end else begin
                                a_reg       <= dividend_mag;
                                b_reg       <= divisor_mag;
                                sign_a_reg  <= is_signed & dividend[WIDTH-1];
                                sign_b_reg  <= is_signed & divisor[WIDTH-1];
                                p_reg       <= '0;
                                count_reg   <= '0;
                                div_by_zero <= 1'b0;
                                state_reg   <= ITER;
                            end
                        end
                    end
                    ITER: begin
                        p_reg     <= step_rem;
                        a_reg     <= {a_reg[WIDTH-2:0], step_qbit};
                        count_reg <= count_reg + 1'b1;
                        if (count_reg == LAST_ITER) begin
                            state_reg <= FIX;
                        end
                    end
                    FIX: begin
                        // Sign flags are already masked by is_signed at capture.
                        quotient  <= (sign_a_reg ^ sign_b_reg) ? -a_reg : a_reg;
                        remainder <= sign_a_reg ? -p_reg : p_reg;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end
                    DONE: begin
                        state_reg <= IDLE;
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
